// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy states,
// default widths and field offsets inside the packed per-stage payloads.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CNT_W  = 16;

    // ID/IX payload: {imm[31:16], rs2[15:11], rs1[10:6], opcode[5:0]}
    localparam int IDIX_OPCODE_LSB = 0;
    localparam int IDIX_RS1_LSB    = 6;
    localparam int IDIX_RS2_LSB    = 11;
    localparam int IDIX_IMM_LSB    = 16;

    // IX/MEM payload: {alu_res[31:8], rd[7:3], mem_op[2:0]}
    localparam int IXMEM_MEMOP_LSB = 0;
    localparam int IXMEM_RD_LSB    = 3;
    localparam int IXMEM_ALU_LSB   = 8;

    // MEM/WB payload: {wb_val[31:6], rd[5:1], wb_en[0]}
    localparam int MEMWB_WBEN_LSB  = 0;
    localparam int MEMWB_RD_LSB    = 1;
    localparam int MEMWB_VAL_LSB   = 6;

    function automatic stage_state_t stage_state(input logic main_vld, input logic skid_vld);
        stage_state_t st;
        if (skid_vld) begin
            st = ST_SKID;
        end else if (main_vld) begin
            st = ST_FULL;
        end else begin
            st = ST_EMPTY;
        end
        return st;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and
// the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count register: reset, clear, or saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else if (clr) begin
            cnt_q <= {W{1'b0}};
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, registered in_ready,
// flush with bubble insertion and a saturating stall-cycle counter.
module pipe_skid_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = PIPE_DATA_W,
    parameter bit ZERO_BUBBLE = 1'b1,
    parameter int CNT_W       = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              stalled,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_vld_q, main_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic              in_ready_q;
    logic              stalled_q;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              stall_s;

    assign in_fire_s  = in_valid & in_ready_q;
    assign out_fire_s = main_vld_q & out_ready;
    assign stall_s    = main_vld_q & ~out_ready;

    // Next-state of the main/skid entries; the valid pair encodes EMPTY/FULL/SKID.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        case (stage_state(main_vld_q, skid_vld_q))
            ST_EMPTY: begin
                if (in_fire_s) begin
                    main_vld_d = 1'b1;
                    main_d     = in_data;
                end else begin
                    main_vld_d = 1'b0;
                end
            end
            ST_FULL: begin
                if (in_fire_s && out_fire_s) begin
                    main_d = in_data;
                end else if (in_fire_s) begin
                    skid_vld_d = 1'b1;
                    skid_d     = in_data;
                end else if (out_fire_s) begin
                    main_vld_d = 1'b0;
                    main_d     = ZERO_BUBBLE ? {DATA_W{1'b0}} : main_q;
                end else begin
                    main_d = main_q;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so only the drain into main can happen.
                if (out_fire_s) begin
                    main_d     = skid_q;
                    skid_vld_d = 1'b0;
                end else begin
                    main_d = main_q;
                end
            end
            default: begin
                main_vld_d = 1'b0;
                skid_vld_d = 1'b0;
                main_d     = {DATA_W{1'b0}};
            end
        endcase
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_d     = ZERO_BUBBLE ? {DATA_W{1'b0}} : main_q;
        end else begin
            skid_d = skid_d;
        end
    end

    // Stage registers; in_ready is precomputed from the next skid occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= {DATA_W{1'b0}};
            skid_q     <= {DATA_W{1'b0}};
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            stalled_q  <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= ~skid_vld_d;
            stalled_q  <= stall_s & ~flush;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (stall_s),
        .cnt (stall_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;
    assign stalled   = stalled_q;

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// Directed self-checking bench for pipe_skid_stage_reg (CNT_W=4 so that
// saturation is reachable in a short run).
module tb_pipe_skid_stage_reg;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready, cnt_clr;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, stalled;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_skid_stage_reg #(.DATA_W(DW), .ZERO_BUBBLE(1'b1), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stalled   (stalled),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [31:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_iready"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, "_odata"}, out_data, 32'd0);
        check_val({tag, "_cnt"}, {28'd0, stall_cnt}, 32'd0);
        check_val({tag, "_stalled"}, {31'd0, stalled}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        push(1'b0, 32'd0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        check_reset_vals("rst");
        tick();
        check_reset_vals("idle");

        // Streaming at full throughput.
        push(1'b1, 32'h11, 1'b1); tick();
        check_val("s1_data", out_data, 32'h11);
        check_val("s1_valid", {31'd0, out_valid}, 32'd1);
        check_val("s1_ready", {31'd0, in_ready}, 32'd1);
        push(1'b1, 32'h22, 1'b1); tick();
        check_val("s2_data", out_data, 32'h22);
        check_val("s2_ready", {31'd0, in_ready}, 32'd1);
        push(1'b1, 32'h33, 1'b1); tick();
        check_val("s3_data", out_data, 32'h33);
        push(1'b0, 32'h0, 1'b1); tick();
        check_val("s_end_valid", {31'd0, out_valid}, 32'd0);
        check_val("s_end_bubble", out_data, 32'd0);
        check_val("s_cnt", {28'd0, stall_cnt}, 32'd0);

        // Backpressure into the skid entry, then drain in order.
        push(1'b1, 32'hA1, 1'b1); tick();
        check_val("bp_a1", out_data, 32'hA1);
        push(1'b1, 32'hB2, 1'b0); tick();
        check_val("bp_ready_low", {31'd0, in_ready}, 32'd0);
        check_val("bp_hold_a1", out_data, 32'hA1);
        check_val("bp_cnt1", {28'd0, stall_cnt}, 32'd1);
        push(1'b0, 32'h0, 1'b0);
        tick(); tick(); tick();
        check_val("bp_cnt4", {28'd0, stall_cnt}, 32'd4);
        check_val("bp_stalled", {31'd0, stalled}, 32'd1);
        check_val("bp_stable", out_data, 32'hA1);
        push(1'b0, 32'h0, 1'b1); tick();
        check_val("bp_b2", out_data, 32'hB2);
        check_val("bp_b2_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp_ready_back", {31'd0, in_ready}, 32'd1);
        check_val("bp_unstalled", {31'd0, stalled}, 32'd0);
        tick();
        check_val("bp_empty", {31'd0, out_valid}, 32'd0);
        check_val("bp_cnt_kept", {28'd0, stall_cnt}, 32'd4);

        // Flush while in SKID with a concurrent input.
        push(1'b1, 32'hA1, 1'b1); tick();
        push(1'b1, 32'hB2, 1'b0); tick();
        check_val("fl_skid", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        push(1'b1, 32'hC3, 1'b0); tick();
        flush = 1'b0;
        check_val("fl_valid", {31'd0, out_valid}, 32'd0);
        check_val("fl_data", out_data, 32'd0);
        check_val("fl_ready", {31'd0, in_ready}, 32'd1);
        check_val("fl_stalled", {31'd0, stalled}, 32'd0);
        check_val("fl_cnt", {28'd0, stall_cnt}, 32'd6);
        push(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("fl_no_out", {31'd0, out_valid}, 32'd0);
        end

        // Saturation of the 4-bit counter and clear-beats-increment.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check_val("sat_clr", {28'd0, stall_cnt}, 32'd0);
        push(1'b1, 32'h77, 1'b0); tick();
        push(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check_val("sat_15", {28'd0, stall_cnt}, 32'd15);
        check_val("sat_data", out_data, 32'h77);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check_val("sat_clr_wins", {28'd0, stall_cnt}, 32'd0);
        tick();
        check_val("sat_restart", {28'd0, stall_cnt}, 32'd1);

        // Reset with flush while in SKID, then a fresh transfer.
        push(1'b1, 32'h88, 1'b0); tick();
        check_val("rs_skid", {31'd0, in_ready}, 32'd0);
        rst = 1'b1; flush = 1'b1;
        push(1'b1, 32'h99, 1'b0); tick();
        rst = 1'b0; flush = 1'b0;
        check_reset_vals("rs");
        push(1'b1, 32'h5A, 1'b1); tick();
        check_val("rs_5a_valid", {31'd0, out_valid}, 32'd1);
        check_val("rs_5a_data", out_data, 32'h5A);
        push(1'b0, 32'h0, 1'b1); tick();
        check_val("rs_drained", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
